// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the buffered UART core.
package uart_fifo_pkg;

    localparam int MAX_DATA_W = 16;
    localparam int ERR_PARITY = 1;
    localparam int ERR_FRAME  = 0;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [1:0]            err;
    } rx_word_t;

    // A length of 0, or one wider than the datapath, means "full width".
    function automatic int eff_len(input int len, input int max_w);
        return (len == 0 || len > max_w) ? max_w : len;
    endfunction

endpackage

// File: rtl/uart_fifo_core_if.sv
// Host-side valid/ready bundle for the UART TX and RX FIFOs.
interface uart_fifo_core_if #(parameter int DATA_W = 8);
    import uart_fifo_pkg::*;

    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic [1:0]        rx_err;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_err
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_err
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from the occupancy counter.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    assign wr_ready = (level != LVL_W'(DEPTH));
    assign rd_valid = (level != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_ready & rd_valid;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Buffered UART: shared baud tick, TX serialiser, mid-bit RX deserialiser.
// Optional UART_LOOPBACK_EN adds a loopback input that feeds txd into the RX path.
module uart_fifo_core
    import uart_fifo_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int OVERSAMPLE = 16,
    localparam int LEN_W      = $clog2(DATA_W + 1),
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      baud_div,
    input  logic [LEN_W-1:0] length,
    input  logic             parity_en,
    input  logic             parity_type,
    input  logic             stop2,
    uart_fifo_core_if.slave  host,
    output logic             rx_overrun,
    output logic [LVL_W-1:0] tx_level,
    output logic [LVL_W-1:0] rx_level,
    output logic             tx_busy,
    output logic             txd,
    input  logic             rxd
`ifdef UART_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic [15:0]       baud_cnt;
    logic              tick;
    logic [LEN_W-1:0]  cfg_len;
    logic [DATA_W-1:0] len_mask;

    // >= keeps the counter from running the full 16-bit range if baud_div shrinks.
    assign tick     = (baud_cnt >= baud_div);
    assign cfg_len  = LEN_W'(eff_len(int'(length), DATA_W));
    assign len_mask = {DATA_W{1'b1}} >> (LEN_W'(DATA_W) - cfg_len);

    always_ff @(posedge clk) begin
        if (rst || tick) baud_cnt <= '0;
        else             baud_cnt <= baud_cnt + 1'b1;
    end

    // ---------------- TX ----------------
    tx_state_e         tx_state, tx_state_nx;
    logic [CNT_W-1:0]  tx_cnt;
    logic [LEN_W-1:0]  tx_bit, tx_len;
    logic [DATA_W-1:0] tx_sh, tx_f_data;
    logic              tx_par, tx_par_en, tx_stop2, tx_stop_idx;
    logic              tx_f_valid, tx_pop, tx_bit_end;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (host.tx_valid),
        .wr_ready (host.tx_ready),
        .wr_data  (host.tx_data),
        .rd_valid (tx_f_valid),
        .rd_ready (tx_pop),
        .rd_data  (tx_f_data),
        .level    (tx_level)
    );

    assign tx_bit_end = tick && (tx_cnt == CNT_W'(OVERSAMPLE - 1));
    assign tx_busy    = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        txd         = 1'b1;
        case (tx_state)
            TX_IDLE: if (tick && tx_f_valid) begin
                tx_pop      = 1'b1;
                tx_state_nx = TX_START;
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_bit_end) tx_state_nx = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_sh[0];
                if (tx_bit_end && tx_bit == tx_len - 1'b1)
                    tx_state_nx = tx_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                txd = tx_par;
                if (tx_bit_end) tx_state_nx = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (tx_bit_end && (!tx_stop2 || tx_stop_idx)) begin
                    tx_pop      = tx_f_valid;
                    tx_state_nx = tx_f_valid ? TX_START : TX_IDLE;
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_len      <= '0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_stop_idx <= 1'b0;
        end else if (tx_pop) begin
            tx_sh       <= tx_f_data & len_mask;
            tx_len      <= cfg_len;
            tx_par      <= ^(tx_f_data & len_mask) ^ parity_type;
            tx_par_en   <= parity_en;
            tx_stop2    <= stop2;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
        end else if (tick && tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 1'b1;
                end
                if (tx_state == TX_STOP) tx_stop_idx <= 1'b1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX ----------------
    logic              rx_in, rxs;
    logic [1:0]        rxd_pipe;
    rx_state_e         rx_state, rx_state_nx;
    logic [CNT_W-1:0]  rx_cnt;
    logic [LEN_W-1:0]  rx_bit, rx_len;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_par_acc, rx_par_en, rx_ptype, rx_stop2, rx_stop_idx;
    logic              rx_perr, rx_ferr;
    logic              rx_sample, rx_start_det, rx_push, rx_f_wr_ready;
    logic [1:0]        rx_push_err;
    logic [DATA_W+1:0] rx_f_data;

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? txd : rxd;
`else
    assign rx_in = rxd;
`endif

    always_ff @(posedge clk) begin
        if (rst) rxd_pipe <= '1;
        else     rxd_pipe <= {rxd_pipe[0], rx_in};
    end
    assign rxs = rxd_pipe[1];

    // START waits half a bit to land mid-bit; every later sample is a full bit apart.
    assign rx_sample = tick && (rx_cnt == ((rx_state == RX_START) ?
                                CNT_W'(OVERSAMPLE / 2 - 1) : CNT_W'(OVERSAMPLE - 1)));
    assign rx_start_det = (rx_state == RX_IDLE) && tick && !rxs;

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_push     = 1'b0;
        case (rx_state)
            RX_IDLE:   if (rx_start_det) rx_state_nx = RX_START;
            RX_START:  if (rx_sample) rx_state_nx = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit == rx_len - 1'b1)
                           rx_state_nx = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_state_nx = RX_STOP;
            RX_STOP:   if (rx_sample && (!rx_stop2 || rx_stop_idx)) begin
                rx_push     = 1'b1;
                rx_state_nx = RX_IDLE;
            end
            default:   rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_len      <= '0;
            rx_sh       <= '0;
            rx_par_acc  <= 1'b0;
            rx_par_en   <= 1'b0;
            rx_ptype    <= 1'b0;
            rx_stop2    <= 1'b0;
            rx_stop_idx <= 1'b0;
            rx_perr     <= 1'b0;
            rx_ferr     <= 1'b0;
        end else if (rx_start_det) begin
            rx_len      <= cfg_len;
            rx_par_en   <= parity_en;
            rx_ptype    <= parity_type;
            rx_stop2    <= stop2;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_sh       <= '0;
            rx_par_acc  <= 1'b0;
            rx_stop_idx <= 1'b0;
            rx_perr     <= 1'b0;
            rx_ferr     <= 1'b0;
        end else if (tick && rx_state != RX_IDLE) begin
            if (rx_sample) begin
                rx_cnt <= '0;
                case (rx_state)
                    RX_DATA: begin
                        rx_sh      <= {rxs, rx_sh[DATA_W-1:1]};
                        rx_par_acc <= rx_par_acc ^ rxs;
                        rx_bit     <= rx_bit + 1'b1;
                    end
                    RX_PARITY: rx_perr <= (rxs != (rx_par_acc ^ rx_ptype));
                    RX_STOP: begin
                        if (!rxs) rx_ferr <= 1'b1;
                        rx_stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Frame error folds in the stop sample being taken in the push cycle.
    always_comb begin
        rx_push_err             = '0;
        rx_push_err[ERR_PARITY] = rx_perr;
        rx_push_err[ERR_FRAME]  = rx_ferr | ~rxs;
    end

    always_ff @(posedge clk) begin
        if (rst) rx_overrun <= 1'b0;
        else     rx_overrun <= rx_push & ~rx_f_wr_ready;
    end

    uart_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (rx_push),
        .wr_ready (rx_f_wr_ready),
        .wr_data  ({rx_sh >> (LEN_W'(DATA_W) - rx_len), rx_push_err}),
        .rd_valid (host.rx_valid),
        .rd_ready (host.rx_ready),
        .rd_data  (rx_f_data),
        .level    (rx_level)
    );

    assign host.rx_data = rx_f_data[DATA_W+1:2];
    assign host.rx_err  = rx_f_data[1:0];

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed scoreboard bench for uart_fifo_core (8-bit, depth 16, 16x oversampling).
module tb_uart_fifo_core;
    import uart_fifo_pkg::*;

    localparam int DATA_W = 8, FIFO_DEPTH = 16, OVERSAMPLE = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] baud_div = '0;
    logic [3:0]  length = 4'd8;
    logic        parity_en = 1'b0, parity_type = 1'b0, stop2 = 1'b0;
    logic        rx_overrun, tx_busy, txd, rxd;
    logic        rxd_drv = 1'b1, lb = 1'b0;
    logic [4:0]  tx_level, rx_level;

    int          n_vec = 0, n_err = 0, ovr_cnt = 0, flen = 0;
    logic        samp [0:399];
    rx_word_t    sb [$];

    always #5 clk = ~clk;
    assign rxd = lb ? txd : rxd_drv;

    uart_fifo_core_if #(.DATA_W(DATA_W)) bus ();

    uart_fifo_core #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .host        (bus),
        .rx_overrun  (rx_overrun),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .tx_busy     (tx_busy),
        .txd         (txd),
`ifdef UART_LOOPBACK_EN
        .loopback    (1'b0),
`endif
        .rxd         (rxd)
    );

    always @(negedge clk) if (rx_overrun) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rx(input logic [7:0] d, input logic [1:0] e);
        rx_word_t w;
        w.data      = '0;
        w.data[7:0] = d;
        w.err       = e;
        sb.push_back(w);
    endtask

    task automatic tx_send(input logic [7:0] d);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag);
        rx_word_t w;
        int n = 0;
        while (!bus.rx_valid && n < 5000) begin @(negedge clk); n++; end
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        if (bus.rx_valid && sb.size() > 0) begin
            w = sb.pop_front();
            check({tag, "_data"}, 32'(bus.rx_data), 32'(w.data));
            check({tag, "_err"},  32'(bus.rx_err),  32'(w.err));
            bus.rx_ready = 1'b1;
            @(negedge clk);
            bus.rx_ready = 1'b0;
        end
    endtask

    // Record txd every clock from the start bit until tx_busy drops.
    task automatic watch_tx(input string tag);
        int n = 0;
        while (txd && n < 400) begin @(negedge clk); n++; end
        check({tag, "_start"}, 32'(txd), 32'd0);
        flen    = 0;
        samp[0] = txd;
        while (tx_busy && flen < 399) begin
            @(negedge clk);
            flen++;
            samp[flen] = txd;
        end
    endtask

    // Bench-driven serial frame at 16 clks per bit (baud_div = 0).
    task automatic send_frame(input logic [7:0] d, input int len, input logic pen,
                              input logic ptype, input logic flip, input logic stop_v,
                              input logic two_stop);
        logic p;
        p = ptype ^ flip;
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < len; i++) begin
            rxd_drv = d[i];
            p       = p ^ d[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rxd_drv = p;
            repeat (16) @(negedge clk);
        end
        rxd_drv = stop_v;
        repeat (two_stop ? 32 : 16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_frame;
        logic [7:0]  d;
        int          acc, n, ovr0;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd",      32'(txd),          32'd1);
        check("rst_busy",     32'(tx_busy),      32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_tx_level", 32'(tx_level),     32'd0);
        check("rst_rx_level", 32'(rx_level),     32'd0);
        check("rst_overrun",  32'(rx_overrun),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 loopback: start, 0xA5 LSB first, stop
        lb = 1'b1;
        exp_frame = 16'h034A;
        expect_rx(8'hA5, 2'b00);
        tx_send(8'hA5);
        watch_tx("a5");
        check("a5_len", 32'(flen), 32'd160);
        for (int i = 0; i < 10; i++) check("a5_bit", 32'(samp[16*i+8]), 32'(exp_frame[i]));
        pop_rx("a5_rx");

        // 7 bits, even parity, two stops: parity bit 0, 11-bit frame
        length = 4'd7; parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b1;
        exp_frame = 16'h06AA;
        expect_rx(8'h55, 2'b00);
        tx_send(8'h55);
        watch_tx("p55");
        check("p55_len", 32'(flen), 32'd176);
        for (int i = 0; i < 11; i++) check("p55_bit", 32'(samp[16*i+8]), 32'(exp_frame[i]));
        pop_rx("p55_rx");

        // Bench-driven frames with injected errors; length 0 means full width
        lb = 1'b0; length = 4'd0; parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b0;
        expect_rx(8'h3C, 2'b10);
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        pop_rx("perr");
        parity_en = 1'b0;
        expect_rx(8'h3C, 2'b01);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_rx("ferr");

        // 17 frames with the host stalled: 16 kept, one overrun
        ovr0 = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 37 + 5);
            if (i < 16) expect_rx(d, 2'b00);
            send_frame(d, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("ovr_level", 32'(rx_level), 32'd16);
        check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        for (int i = 0; i < 16; i++) pop_rx("ovr");

        // 5-clk low glitch is a false start
        rxd_drv = 1'b0;
        repeat (5) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_valid", 32'(bus.rx_valid), 32'd0);
        check("glitch_level", 32'(rx_level), 32'd0);

        // Slow baud: one word in the shifter plus a full FIFO
        baud_div = 16'd99;
        tx_send(8'h11);
        acc = 1;
        n = 0;
        while (!tx_busy && n < 400) begin @(negedge clk); n++; end
        check("fill_busy", 32'(tx_busy), 32'd1);
        while (bus.tx_ready && acc < 40) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'(acc);
            @(negedge clk);
            acc++;
        end
        bus.tx_valid = 1'b0;
        check("fill_accepted", 32'(acc), 32'd17);
        check("fill_level", 32'(tx_level), 32'd16);
        check("fill_ready", 32'(bus.tx_ready), 32'd0);

        // Reset in the middle of the first data bit
        repeat (3000) @(negedge clk);
        check("mid_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_txd",      32'(txd),          32'd1);
        check("mrst_busy",     32'(tx_busy),      32'd0);
        check("mrst_tx_level", 32'(tx_level),     32'd0);
        check("mrst_rx_level", 32'(rx_level),     32'd0);
        check("mrst_tx_ready", 32'(bus.tx_ready), 32'd1);
        rst = 1'b0;
        baud_div = 16'd0; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
        @(negedge clk);

        lb = 1'b1;
        expect_rx(8'h81, 2'b00);
        tx_send(8'h81);
        pop_rx("post_rst");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
